// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: game-controller bus between button/ball events and the ball animation commands
interface pong_game_ctrl_if #(parameter int SCORE_W = 4);
  logic animate, btn_start, btn_pause, miss_l, miss_r;
  logic [2:0] state;
  logic ball_en, serve, serve_dir, game_over, winner;
  logic [SCORE_W-1:0] score_l, score_r;
  modport master (
    output animate, btn_start, btn_pause, miss_l, miss_r,
    input state, ball_en, serve, serve_dir, score_l, score_r, game_over, winner
  );
  modport slave (
    input animate, btn_start, btn_pause, miss_l, miss_r,
    output state, ball_en, serve, serve_dir, score_l, score_r, game_over, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer tracking state and scores and issuing serve/ball-enable commands
module pong_game_ctrl #(
  parameter int SCORE_W = 4,
  parameter int WIN_SCORE = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int CNT_W = 8
) (
  input logic clk_pix,
  input logic rst,
  pong_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, POINT = 3'd4, OVER = 3'd5} state_t;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  state_t st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SCORE_W-1:0] sl, sr, sl_nx, sr_nx, sl_inc, sr_inc;
  logic be, be_nx, sv, sv_nx, dir, dir_nx, go, go_nx, win, win_nx;
  logic start_q, pause_q, start_e, pause_e, hit_l, hit_r, clr, ent_serve;
  assign start_e = bus.btn_start & ~start_q;
  assign pause_e = bus.btn_pause & ~pause_q;
  // simultaneous misses: the left miss wins
  assign hit_l = st == PLAY && bus.miss_l;
  assign hit_r = st == PLAY && bus.miss_r && !bus.miss_l;
  assign sl_inc = sl + 1'b1;
  assign sr_inc = sr + 1'b1;
  assign clr = start_e && (st == IDLE || st == OVER);
  assign ent_serve = st_nx == SERVE && st != SERVE;
  always_ff @(posedge clk_pix or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      sl <= '0;
      sr <= '0;
      be <= 1'b0;
      sv <= 1'b0;
      dir <= 1'b0;
      go <= 1'b0;
      win <= 1'b0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      sl <= sl_nx;
      sr <= sr_nx;
      be <= be_nx;
      sv <= sv_nx;
      dir <= dir_nx;
      go <= go_nx;
      win <= win_nx;
      start_q <= bus.btn_start;
      pause_q <= bus.btn_pause;
    end
  always_comb begin
    st_nx = st;
    case (st)
      IDLE, OVER: st_nx = start_e ? SERVE : st;
      SERVE: st_nx = (bus.animate && cnt == SERVE_LAST) ? PLAY : SERVE;
      PLAY: st_nx = hit_l ? (sr_inc == WIN ? OVER : POINT) :
                    hit_r ? (sl_inc == WIN ? OVER : POINT) :
                    pause_e ? PAUSE : PLAY;
      PAUSE: st_nx = pause_e ? PLAY : PAUSE;
      POINT: st_nx = (bus.animate && cnt == POINT_LAST) ? SERVE : POINT;
      default: st_nx = IDLE;
    endcase
  end
  // outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    cnt_nx = (ent_serve || hit_l || hit_r) ? '0 :
             ((st == SERVE || st == POINT) && bus.animate) ? cnt + 1'b1 : cnt;
    sl_nx = clr ? '0 : hit_r ? sl_inc : sl;
    sr_nx = clr ? '0 : hit_l ? sr_inc : sr;
    dir_nx = hit_l ? 1'b1 : hit_r ? 1'b0 : dir;
    win_nx = ((hit_l || hit_r) && st_nx == OVER) ? hit_l : win;
    be_nx = st_nx == PLAY;
    sv_nx = st == SERVE && st_nx == PLAY;
    go_nx = st_nx == OVER;
  end
  assign bus.state = st;
  assign bus.ball_en = be;
  assign bus.serve = sv;
  assign bus.serve_dir = dir;
  assign bus.score_l = sl;
  assign bus.score_r = sr;
  assign bus.game_over = go;
  assign bus.winner = win;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for the Pong match sequencer
module tb_pong_game_ctrl;
  logic clk_pix = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  typedef struct {string tag; logic [16:0] v;} exp_t;
  exp_t q[$];
  pong_game_ctrl_if #(.SCORE_W(4)) bus ();
  pong_game_ctrl dut (.clk_pix(clk_pix), .rst(rst), .bus(bus));
  always #5 clk_pix = ~clk_pix;
  logic [16:0] obs;
  assign obs = {bus.state, bus.ball_en, bus.serve, bus.serve_dir, bus.score_l, bus.score_r, bus.game_over, bus.winner};
  function automatic logic [16:0] ex(input logic [2:0] s, input logic be, sv, sd,
                                     input logic [3:0] l, r, input logic go, w);
    return {s, be, sv, sd, l, r, go, w};
  endfunction
  task automatic push(input string tag, input logic [16:0] v);
    q.push_back('{tag: tag, v: v});
  endtask
  task automatic pop_check();
    exp_t e;
    e = q.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask
  task automatic cyc();
    @(posedge clk_pix);
    #1;
  endtask
  task automatic strobe_chk(input string tag, input logic [16:0] v);
    push(tag, v);
    bus.animate = 1'b1;
    cyc();
    bus.animate = 1'b0;
    pop_check();
    cyc();
  endtask
  task automatic countdown(input logic [3:0] l, r, input logic d);
    for (int i = 1; i < 60; i++) strobe_chk("serve_count", ex(3'd1, 0, 0, d, l, r, 0, 0));
    strobe_chk("serve_launch", ex(3'd2, 1, 1, d, l, r, 0, 0));
    push("serve_single", ex(3'd2, 1, 0, d, l, r, 0, 0));
    pop_check();
  endtask
  task automatic point_wait(input logic [3:0] l, r, input logic d);
    for (int i = 1; i < 90; i++) strobe_chk("point_count", ex(3'd4, 0, 0, d, l, r, 0, 0));
    strobe_chk("point_done", ex(3'd1, 0, 0, d, l, r, 0, 0));
  endtask
  task automatic miss(input string tag, input logic ml, mr, input logic [16:0] v);
    push(tag, v);
    bus.miss_l = ml;
    bus.miss_r = mr;
    cyc();
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    pop_check();
  endtask
  initial begin
    bus.animate = 1'b0;
    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b0;
    bus.miss_l = 1'b0;
    bus.miss_r = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    push("reset", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    rst = 1'b0;
    repeat (3) cyc();
    push("held_start", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    bus.btn_start = 1'b0;
    cyc();
    push("start_low", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    bus.btn_start = 1'b1;
    push("start_edge", ex(3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    cyc();
    pop_check();
    bus.btn_start = 1'b0;
    cyc();
    countdown(4'd0, 4'd0, 1'b0);
    miss("miss_l", 1, 0, ex(3'd4, 0, 0, 1, 4'd0, 4'd1, 0, 0));
    point_wait(4'd0, 4'd1, 1'b1);
    countdown(4'd0, 4'd1, 1'b1);
    bus.btn_pause = 1'b1;
    push("pause", ex(3'd3, 0, 0, 1, 4'd0, 4'd1, 0, 0));
    cyc();
    pop_check();
    bus.btn_pause = 1'b0;
    cyc();
    miss("pause_miss", 0, 1, ex(3'd3, 0, 0, 1, 4'd0, 4'd1, 0, 0));
    bus.btn_pause = 1'b1;
    push("resume", ex(3'd2, 1, 0, 1, 4'd0, 4'd1, 0, 0));
    cyc();
    pop_check();
    bus.btn_pause = 1'b0;
    cyc();
    push("resume_hold", ex(3'd2, 1, 0, 1, 4'd0, 4'd1, 0, 0));
    pop_check();
    bus.btn_pause = 1'b1;
    miss("both_miss", 1, 1, ex(3'd4, 0, 0, 1, 4'd0, 4'd2, 0, 0));
    bus.btn_pause = 1'b0;
    point_wait(4'd0, 4'd2, 1'b1);
    countdown(4'd0, 4'd2, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      miss("miss_r", 0, 1, ex(3'd4, 0, 0, 0, 4'(k), 4'd2, 0, 0));
      point_wait(4'(k), 4'd2, 1'b0);
      countdown(4'(k), 4'd2, 1'b0);
    end
    miss("win_left", 0, 1, ex(3'd5, 0, 0, 0, 4'd9, 4'd2, 1, 0));
    cyc();
    miss("over_miss", 1, 0, ex(3'd5, 0, 0, 0, 4'd9, 4'd2, 1, 0));
    bus.btn_start = 1'b1;
    push("restart", ex(3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    cyc();
    pop_check();
    bus.btn_start = 1'b0;
    cyc();
    repeat (3) strobe_chk("serve_pre_rst", ex(3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    #2 rst = 1'b1;
    #1 push("rst_mid_serve", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    cyc();
    rst = 1'b0;
    cyc();
    bus.btn_start = 1'b1;
    bus.animate = 1'b1;
    push("start_with_animate", ex(3'd1, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    cyc();
    bus.animate = 1'b0;
    bus.btn_start = 1'b0;
    pop_check();
    cyc();
    countdown(4'd0, 4'd0, 1'b0);
    #2 rst = 1'b1;
    #1 push("rst_mid_play", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    cyc();
    rst = 1'b0;
    cyc();
    push("idle_after_rst", ex(3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0));
    pop_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the Pong display pipeline, clocked alongside the ball and paddle animation logic in the pixel-clock domain. Tracks match state (idle, serve countdown, play, pause, point pause, game over), keeps both scores, and issues serve, ball-enable and serve-direction commands to the ball animation. Consumes the once-per-frame `animate` strobe plus edge-miss events from the ball logic, and start/pause buttons that are already synchronised and debounced.

## Interface

- `SCORE_W`, 4: score counter width in bits.
- `WIN_SCORE`, 9: score that ends the match; must be between 1 and 2^SCORE_W−1.
- `SERVE_FRAMES`, 60: frames of countdown before each serve; minimum 1.
- `POINT_FRAMES`, 90: frames of pause after a point; minimum 1.
- `CNT_W`, 8: frame counter width; must satisfy 2^CNT_W > max(SERVE_FRAMES, POINT_FRAMES).

- `clk_pix`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `animate`  in  1  one-cycle strobe at the start of vertical blanking.
- `btn_start`  in  1  start button level, synchronised and debounced.
- `btn_pause`  in  1  pause button level, synchronised and debounced.
- `miss_l`  in  1  one-cycle pulse: ball reached the left edge (right player scores).
- `miss_r`  in  1  one-cycle pulse: ball reached the right edge (left player scores).
- `state`  out  3  encoding: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5.
- `ball_en`  out  1  ball movement enable.
- `serve`  out  1  one-cycle pulse: recentre the ball and launch it.
- `serve_dir`  out  1  launch direction: 0 = right, 1 = left.
- `score_l`, `score_r`  out  SCORE_W  player scores.
- `game_over`  out  1  high while in OVER.
- `winner`  out  1  0 = left, 1 = right; meaningful only when `game_over` is high.

## Operation

- All outputs are registered.
- Reset values: `state` = IDLE, `ball_en` = 0, `serve` = 0, `serve_dir` = 0, scores = 0, `game_over` = 0, `winner` = 0, frame counter = 0.
- Edge detection:
  - The start edge is `btn_start` high while its previous sample was low; the pause edge is defined the same way.
  - Both previous-sample registers reset to 1, so a button held through reset produces no edge.
- IDLE:
  - Scores hold their values.
  - A start edge clears both scores, clears the counter and moves to SERVE.
- SERVE:
  - `ball_en` = 0.
  - Each `animate` increments the counter.
  - An `animate` while the counter equals SERVE_FRAMES−1 moves to PLAY, pulses `serve` and sets `ball_en` = 1.
- PLAY, on `miss_l`:
  - `score_r` increments and `serve_dir` is set to 1 (the next serve goes toward the conceding player).
  - The counter clears.
  - If the new `score_r` equals WIN_SCORE, go to OVER with `winner` = 1; otherwise go to POINT.
- PLAY, on `miss_r`:
  - Mirror of `miss_l`: `score_l` increments, `serve_dir` = 0, `winner` = 0 on game end.
- PLAY, simultaneous `miss_l` and `miss_r`: `miss_l` has priority and `miss_r` is discarded.
- PLAY, pause edge: go to PAUSE. A pause edge and a miss in the same cycle: the miss wins and the pause edge is discarded.
- PAUSE:
  - `ball_en` = 0 and misses are ignored.
  - A pause edge returns to PLAY with `ball_en` = 1 and no `serve` pulse.
- POINT:
  - `ball_en` = 0 and misses are ignored.
  - An `animate` while the counter equals POINT_FRAMES−1 moves to SERVE and clears the counter.
- OVER:
  - `game_over` = 1; scores and `winner` hold.
  - A start edge clears scores, `game_over` and the counter, then moves to SERVE.
- Button edges are ignored in every state not listed above.
- Score arithmetic is unsigned. No wrap is possible because the match ends at WIN_SCORE.

## Timing

- Every state change and output change becomes visible on the cycle after the triggering input is sampled.
- `serve` is high for exactly one cycle, coincident with the first cycle of `state` = PLAY.
- SERVE dwell is exactly SERVE_FRAMES `animate` strobes. The transition happens on the strobe that completes the count.
- POINT dwell is exactly POINT_FRAMES strobes.
- An `animate` arriving in the same cycle as a state-entry event does not count toward the new state.
- `rst` asserted at any time immediately forces all registers to their reset values. On deassertion the block resumes in IDLE on the next clock.

## Test plan

- **Serve countdown:** Reset, then start edge, then 60 `animate` strobes.
  - `state` is SERVE for strobes 1–59.
  - After strobe 60: `state` = PLAY, a single-cycle `serve` pulse, `ball_en` = 1, `serve_dir` = 0.
- **Left miss:** `miss_l` in PLAY.
  - `score_r` = 1, `serve_dir` = 1, `state` = POINT, `ball_en` = 0.
  - After 90 strobes `state` = SERVE; after 60 more strobes a `serve` pulse occurs.
- **Match end:** Drive `score_l` to 8, then `miss_r`.
  - `score_l` = 9, `state` = OVER, `game_over` = 1, `winner` = 0.
  - A subsequent start edge gives scores 0, `game_over` = 0, `state` = SERVE.
- **Pause and simultaneous events:**
  - Pause edge in PLAY gives PAUSE. `miss_r` in PAUSE leaves scores unchanged. A second pause edge gives PLAY, `ball_en` = 1, no `serve`.
  - `miss_l` and `miss_r` in the same cycle: only `score_r` increments.
- **Reset behaviour:**
  - `btn_start` held high across reset release: `state` stays IDLE until the button goes low then high.
  - `rst` pulsed mid-SERVE and mid-PLAY: all outputs return to reset values within the same cycle.
